// File: rtl/mdu_iter.sv
// Iterative MIPS HI/LO multiply-divide unit: radix-2 shift-add multiply and
// restoring divide, 32 CALC cycles, then one sign-fix cycle and one result cycle.
module mdu_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] a_q, a_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        is_div_q, is_div_d, dz_q, dz_d;
    logic        neg_q, neg_d, rneg_q, rneg_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        supported, signed_op, div_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, prem, pdiff;
    logic [63:0] prod;
    logic [31:0] quo, rmd;

    assign supported = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign div_op    = (funct == F_DIV) || (funct == F_DIVU);
    assign a_mag     = (signed_op && a[31]) ? -a : a;
    assign b_mag     = (signed_op && b[31]) ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide: 33-bit partial remainder; bit 32 of the difference is the borrow.
    assign prem    = {rem_q, acc_q[31]};
    assign pdiff   = prem - {1'b0, opb_q};

    assign prod = neg_q  ? -acc_q        : acc_q;
    assign quo  = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
    assign rmd  = rneg_q ? -rem_q        : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && supported) begin
                    a_d      = a;
                    opb_d    = div_op ? b_mag : a_mag;
                    acc_d    = {32'd0, div_op ? a_mag : b_mag};
                    rem_d    = '0;
                    cnt_d    = '0;
                    is_div_d = div_op;
                    dz_d     = div_op && (b == 32'd0);
                    neg_d    = signed_op && (a[31] ^ b[31]);
                    rneg_d   = signed_op && a[31];
                    state_d  = CALC;
                end
                CALC: begin
                    cnt_d = cnt_q + 5'd1;
                    if (is_div_q) begin
                        acc_d = {32'd0, acc_q[30:0], ~pdiff[32]};
                        rem_d = pdiff[32] ? prem[31:0] : pdiff[31:0];
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    if (cnt_q == 5'd31) state_d = FIX;
                end
                FIX: begin
                    if (dz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rmd;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                    state_d = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi_we = done_q;
    assign lo_we = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected {hi,lo} queued at start, checked at done.
module tb_mdu_iter;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        busy, done, hi_we, lo_we;
    logic [31:0] hi, lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = '0;

    mdu_iter dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {hi, lo} as MIPS defines them.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (f)
            F_MULT:  return sx * sy;
            F_MULTU: return ux * uy;
            F_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = ux / uy;
                r = ux % uy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Issue one op; optionally pulse a stray start at cycle 'ghost' while busy.
    task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input int ghost);
        logic [63:0] e;
        logic        got, busy_ok;
        int          c;
        exp_q.push_back(model(f, x, y));
        funct = f; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        got = 1'b0; busy_ok = 1'b1; c = 1;
        while (!got && c <= 40) begin
            if (done === 1'b1) begin
                got = 1'b1;
                e = exp_q.pop_front();
                n_vec++;
                if (c != 34) begin
                    n_err++;
                    $display("FAIL %s latency: done at cycle %0d, want 34", name, c);
                end
                n_vec++;
                if ({hi, lo} !== e) begin
                    n_err++;
                    $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
                end
                n_vec++;
                if ({busy, hi_we, lo_we} !== 3'b011) begin
                    n_err++;
                    $display("FAIL %s done_flags: busy/hi_we/lo_we=%b, want 011", name, {busy, hi_we, lo_we});
                end
                last_res = e;
            end else begin
                if (c <= 33 && busy !== 1'b1) busy_ok = 1'b0;
                if (c == ghost) begin
                    start = 1'b1; funct = F_MULTU;
                end
                tick();
                start = 1'b0;
                c++;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no done within 40 cycles, want done at 34", name);
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end else begin
            n_vec++;
            if (!busy_ok) begin
                n_err++;
                $display("FAIL %s busy: busy low during cycles 1-33, want high", name);
            end
            tick();
            n_vec++;
            if ({done, busy, hi_we, lo_we} !== 4'b0000 || {hi, lo} !== last_res) begin
                n_err++;
                $display("FAIL %s after_done: done/busy/we=%b hi=%h lo=%h, want 0000 and held result",
                         name, {done, busy, hi_we, lo_we}, hi, lo);
            end
        end
    endtask

    // Runs n cycles and reports whether any done pulse appeared.
    task automatic watch_no_done(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL %s: done/hi_we/lo_we pulsed, want none", name);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, hi_we, lo_we} !== 4'b0000 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: flags=%b hi=%h lo=%h, want 0000 0 0", {busy, done, hi_we, lo_we}, hi, lo);
        end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        // first edge after release must accept this start
        do_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_mult();
        logic [31:0] x, y;
        do_op("mult_neg3x5", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 0);
        do_op("mult_minxmin", F_MULT, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("multu_zero", F_MULTU, 32'd0, 32'h1234_5678, 0);
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom;
            do_op("mult_rand", F_MULT, x, y, 0);
            x = $urandom; y = $urandom;
            do_op("multu_rand", F_MULTU, x, y, 0);
        end
    endtask

    task automatic test_div();
        logic [31:0] x, y;
        do_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        do_op("divu_100by7", F_DIVU, 32'd100, 32'd7, 0);
        do_op("div_overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("div_7byneg2", F_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'h0000_0003, 0);
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom >> $urandom_range(0, 31);
            if (y == 32'd0) y = 32'd1;
            do_op("div_rand", F_DIV, x, y, 0);
            x = $urandom; y = $urandom >> $urandom_range(0, 31);
            if (y == 32'd0) y = 32'd1;
            do_op("divu_rand", F_DIVU, x, y, 0);
        end
    endtask

    task automatic test_div_zero();
        do_op("divu_by0", F_DIVU, 32'h0000_0064, 32'd0, 0);
        do_op("div_by0", F_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    endtask

    task automatic test_unsupported();
        funct = 6'h1C; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || {hi, lo} !== last_res) begin
            n_err++;
            $display("FAIL unsupported_funct: busy=%b hi=%h lo=%h, want idle and held result", busy, hi, lo);
        end
        watch_no_done("unsupported_no_done", 36);
    endtask

    task automatic test_flush();
        int c;
        // flush during CALC
        funct = F_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0; c = 1;
        while (c < 10) begin tick(); c++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({busy, done, hi_we, lo_we} !== 4'b0000 || {hi, lo} !== last_res) begin
            n_err++;
            $display("FAIL flush_calc: flags=%b hi=%h lo=%h, want idle, held result", {busy, done, hi_we, lo_we}, hi, lo);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc_done: done=%b, want 0", done);
        end
        do_op("flush_restart", F_MULTU, 32'd3, 32'd4, 0);
        // flush in the FIX cycle must not commit the result
        funct = F_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; c = 1;
        while (c < 33) begin tick(); c++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({done, hi_we, lo_we} !== 3'b000 || {hi, lo} !== last_res) begin
            n_err++;
            $display("FAIL flush_fix: flags=%b hi=%h lo=%h, want 000 and held result", {done, hi_we, lo_we}, hi, lo);
        end
        // flush wins over start in the same IDLE cycle
        funct = F_MULTU; a = 32'd5; b = 32'd6; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_vs_start: busy=%b, want 0", busy);
        end
        watch_no_done("flush_vs_start_no_done", 38);
    endtask

    task automatic test_back_to_back();
        do_op("divu_ghost5", F_DIVU, 32'd100, 32'd7, 5);
        do_op("mult_b2b_ghost33", F_MULT, 32'h7FFF_0001, 32'hFFFF_FF00, 33);
        do_op("div_b2b", F_DIV, 32'h8000_0001, 32'd16, 1);
    endtask

    task automatic test_reset_mid();
        int c;
        funct = F_DIV; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; c = 1;
        while (c < 20) begin tick(); c++; end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, hi_we, lo_we} !== 4'b0000 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: flags=%b hi=%h lo=%h, want 0000 0 0", {busy, done, hi_we, lo_we}, hi, lo);
        end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        last_res = '0;
        watch_no_done("reset_mid_no_done", 40);
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        do_op("post_reset_op", F_DIVU, 32'd77, 32'd5, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; a = '0; b = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_unsupported();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
